// File: rtl/vnc_packer.sv
// Purpose: packs the debiased corrector bit stream LSB-first into WIDTH-bit words and queues them in a DEPTH-entry FIFO.
// Latency: a completed word is visible on out_word/out_valid in the cycle right after its final bit's edge.
// Backpressure: out_ready stalls the FIFO head; a word completing while the FIFO is full (and no same-edge pop) is dropped and counted.
module vnc_packer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         in_bit,
    input  logic                         in_valid,
    output logic [WIDTH-1:0]             out_word,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic [CNT_W-1:0]             drop_count,
    input  logic                         clr_stats
);

    localparam int CW = $clog2(WIDTH);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-2:0] shreg_q, shreg_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic             word_done;
    logic [WIDTH-1:0] done_word;
    logic             empty, full, push, pop, drop;

    // Bit assembler: the top bit never lands in shreg, it goes straight into the completed word.
    always_comb begin
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        word_done = in_valid && (cnt_q == CW'(WIDTH - 1));
        done_word = {in_bit, shreg_q};
        if (in_valid) begin
            if (word_done) begin
                cnt_d   = '0;
                shreg_d = '0;
            end else begin
                shreg_d[cnt_q] = in_bit;
                cnt_d          = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop   = !empty && out_ready;
        // A same-edge pop frees the slot, so a full FIFO can still take the new word.
        push  = word_done && (!full || pop);
        drop  = word_done && full && !pop;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = done_word;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // A drop on the same edge as clr_stats counts as the first event after the clear.
    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (clr_stats) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end
        if (drop) begin
            ovf_d = 1'b1;
            if (clr_stats) begin
                drop_d = CNT_W'(1);
            end else if (drop_q != {CNT_W{1'b1}}) begin
                drop_d = drop_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q    <= '0;
            shreg_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
            mem_q    <= mem_d;
        end
    end

    assign out_valid  = !empty;
    assign out_word   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign level      = level_q;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_vnc_packer.sv
// Bench for vnc_packer: queue-based reference model compared every cycle, plus directed literal checks.
module tb_vnc_packer;

    logic       clk;
    logic       rstn;
    logic       in_bit;
    logic       in_valid;
    logic [7:0] out_word;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] level;
    logic       overflow;
    logic [15:0] drop_count;
    logic       clr_stats;

    int checks = 0;
    int errors = 0;

    vnc_packer #(.WIDTH(8), .DEPTH(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_bit     (in_bit),
        .in_valid   (in_valid),
        .out_word   (out_word),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .overflow   (overflow),
        .drop_count (drop_count),
        .clr_stats  (clr_stats)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: list of queued words, bits collected so far, drop tally.
    logic [7:0] mq[$];
    int         mbits = 0;
    logic [7:0] masm  = 8'h00;
    int         mdrops = 0;
    bit         movf  = 1'b0;

    always @(posedge clk or negedge rstn) begin
        bit         mpop;
        bit         mdone;
        logic [7:0] mw;
        if (!rstn) begin
            mq.delete();
            mbits  = 0;
            masm   = 8'h00;
            mdrops = 0;
            movf   = 1'b0;
        end else begin
            mpop  = (mq.size() > 0) && out_ready;
            mdone = 1'b0;
            mw    = 8'h00;
            if (in_valid) begin
                masm[mbits] = in_bit;
                mbits++;
                if (mbits == 8) begin
                    mdone = 1'b1;
                    mw    = masm;
                    mbits = 0;
                    masm  = 8'h00;
                end
            end
            if (mpop) void'(mq.pop_front());
            if (clr_stats) begin
                mdrops = 0;
                movf   = 1'b0;
            end
            if (mdone) begin
                if (mq.size() < 4) mq.push_back(mw);
                else begin
                    movf = 1'b1;
                    if (mdrops < 65535) mdrops++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            check("model_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
            check("model_word", {24'd0, out_word}, (mq.size() > 0) ? {24'd0, mq[0]} : 32'd0);
            check("model_level", {29'd0, level}, mq.size());
            check("model_ovf", {31'd0, overflow}, {31'd0, movf});
            check("model_drops", {16'd0, drop_count}, mdrops);
        end
    end

    task automatic step(input bit v, input bit b);
        in_valid = v;
        in_bit   = b;
        @(negedge clk);
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input bit rdy_last, input bit clr_last);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_bit   = w[i];
            if (i == 7) begin
                if (rdy_last) out_ready = 1'b1;
                clr_stats = clr_last;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        clr_stats = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] exp_words [4];
        rstn      = 1'b0;
        in_bit    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr_stats = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_word", {24'd0, out_word}, 32'd0);
        check("rst_level", {29'd0, level}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_drops", {16'd0, drop_count}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Consecutive bits 1,0,1,1,0,0,0,1 -> 8'h8D
        out_ready = 1'b1;
        pat = 8'h8D;
        for (int i = 0; i < 8; i++) step(1'b1, pat[i]);
        check("t1_valid", {31'd0, out_valid}, 32'd1);
        check("t1_word", {24'd0, out_word}, 32'h8D);
        step(1'b0, 1'b0);
        check("t1_valid_gone", {31'd0, out_valid}, 32'd0);
        check("t1_level", {29'd0, level}, 32'd0);

        // Same bits with idle cycles interleaved
        for (int i = 0; i < 8; i++) begin
            step(1'b1, pat[i]);
            if (i == 6) check("t2_no_early", {31'd0, out_valid}, 32'd0);
            if (i < 7) step(1'b0, 1'b1);
        end
        check("t2_word", {24'd0, out_word}, 32'h8D);
        step(1'b0, 1'b0);

        // Fill with ready low; fifth word overflows
        out_ready = 1'b0;
        for (int w = 1; w <= 5; w++) send_word(8'(w), 1'b0, 1'b0);
        check("t3_level", {29'd0, level}, 32'd4);
        check("t3_head", {24'd0, out_word}, 32'h01);
        check("t3_ovf", {31'd0, overflow}, 32'd1);
        check("t3_drops", {16'd0, drop_count}, 32'd1);
        step(1'b0, 1'b0);
        check("t3_head_held", {24'd0, out_word}, 32'h01);
        out_ready = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            check("t3_drain", {24'd0, out_word}, w);
            step(1'b0, 1'b0);
        end
        check("t3_empty", {31'd0, out_valid}, 32'd0);
        check("t3_level0", {29'd0, level}, 32'd0);

        // Full FIFO with same-edge pop accepts the new word
        clr_stats = 1'b1;
        step(1'b0, 1'b0);
        clr_stats = 1'b0;
        out_ready = 1'b0;
        send_word(8'h11, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0);
        send_word(8'h33, 1'b0, 1'b0);
        send_word(8'h44, 1'b0, 1'b0);
        send_word(8'hAA, 1'b1, 1'b0);
        out_ready = 1'b0;
        check("t4_level", {29'd0, level}, 32'd4);
        check("t4_ovf", {31'd0, overflow}, 32'd0);
        check("t4_head", {24'd0, out_word}, 32'h22);
        exp_words[0] = 8'h22; exp_words[1] = 8'h33;
        exp_words[2] = 8'h44; exp_words[3] = 8'hAA;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t4_drain", {24'd0, out_word}, {24'd0, exp_words[i]});
            step(1'b0, 1'b0);
        end
        check("t4_empty", {31'd0, out_valid}, 32'd0);

        // Async reset mid-word with a word queued
        out_ready = 1'b0;
        send_word(8'h5A, 1'b0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t5_rst_word", {24'd0, out_word}, 32'd0);
        check("t5_rst_level", {29'd0, level}, 32'd0);
        #1 rstn = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        check("t5_valid", {31'd0, out_valid}, 32'd1);
        check("t5_word", {24'd0, out_word}, 32'h00);
        step(1'b0, 1'b0);

        // Stats clear, then clear coinciding with a drop
        out_ready = 1'b0;
        for (int w = 0; w < 7; w++) send_word(8'(8'h30 + w), 1'b0, 1'b0);
        check("t6_ovf", {31'd0, overflow}, 32'd1);
        check("t6_drops3", {16'd0, drop_count}, 32'd3);
        clr_stats = 1'b1;
        step(1'b0, 1'b0);
        clr_stats = 1'b0;
        check("t6_clr_ovf", {31'd0, overflow}, 32'd0);
        check("t6_clr_drops", {16'd0, drop_count}, 32'd0);
        send_word(8'hC3, 1'b0, 1'b1);
        check("t6_both_ovf", {31'd0, overflow}, 32'd1);
        check("t6_both_drops", {16'd0, drop_count}, 32'd1);
        check("t6_head", {24'd0, out_word}, 32'h30);
        out_ready = 1'b1;
        repeat (5) step(1'b0, 1'b0);
        check("t6_empty", {31'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vnc_packer.md
Name: vnc_packer

Overview:
- Sits directly downstream of the von Neumann corrector in the TRNG chain.
- Consumes its debiased single-bit stream (out_bit qualified by valid) and packs accepted bits LSB-first into WIDTH-bit words.
- Buffers completed words in a DEPTH-entry FIFO and presents them to the consumer over a valid/ready handshake.
- Counts words dropped on FIFO overflow for health monitoring.

Parameters:
- WIDTH, 8, output word width in bits; must be ≥2.
- DEPTH, 4, FIFO depth in words; must be a power of 2 and ≥2.
- CNT_W, 16, width of drop_count.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rstn  input  1  asynchronous active-low reset.
- in_bit  input  1  debiased bit from corrector.
- in_valid  input  1  in_bit qualifier; a bit is accepted on every edge where in_valid=1.
- out_word  output  WIDTH  FIFO head word; forced to 0 when FIFO empty.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head word when out_valid=1 on the same edge.
- level  output  $clog2(DEPTH+1)  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky flag: set when a completed word was dropped.
- drop_count  output  CNT_W  saturating count of dropped words.
- clr_stats  input  1  synchronous clear of overflow and drop_count.

Behaviour:
- Reset (async, rstn=0), with everything cleared immediately regardless of clk:
  - bit counter=0 and shift register=0;
  - FIFO empty, pointers=0, level=0;
  - out_valid=0, out_word=0;
  - overflow=0, drop_count=0.
- Reset mid-word: partially assembled bits are discarded; the first bit accepted after reset becomes bit 0 of a new word.
- Bit packing:
  - An accepted bit is written to position cnt of the assembling word, then cnt increments.
  - Edges with in_valid=0 change nothing in the assembler.
- Word completion: on an edge with in_valid=1 and cnt=WIDTH-1:
  - the completed word {in_bit, shreg[WIDTH-2:0]} is offered to the FIFO on that same edge;
  - cnt returns to 0.
- Push acceptance: the completed word is written if the FIFO is not full, or if it is full and a pop occurs on the same edge.
- Pop: occurs on an edge with out_valid=1 and out_ready=1. It advances the read pointer.
- out_word/out_valid:
  - Driven combinationally from FIFO storage and the empty flag.
  - A word pushed into an empty FIFO at edge k is visible with out_valid=1 in the cycle after edge k.
  - Latency from the final bit's edge to out_valid is 0 extra cycles.
- level: updated each edge as +1 (push only), −1 (pop only), or unchanged (both or neither). It never exceeds DEPTH.
- Pointers: log2(DEPTH)+1 bits with natural wrap.
  - full = (MSBs differ && LSBs equal).
  - empty = (pointers equal).
- Overflow: on word completion with FIFO full and no same-edge pop:
  - the word is dropped and FIFO contents are unchanged;
  - overflow<=1;
  - drop_count<=drop_count+1, saturating at all-ones.
- clr_stats=1 clears overflow and drop_count at the edge. Data path, FIFO and assembler are unaffected.
- clr_stats coinciding with a drop: the new event wins, so overflow=1 and drop_count=1 after the edge.
- Pop on empty is impossible (out_valid=0); out_ready is ignored while empty.
- out_word must be stable while out_valid=1 and out_ready=0.

Test Plan:
- WIDTH=8, DEPTH=4, out_ready=1; bits 1,0,1,1,0,0,0,1 on 8 consecutive edges with in_valid=1 -> out_word=8'h8D, out_valid=1 for exactly one cycle after the 8th edge, then level=0.
- Same 8 bits with in_valid=0 inserted between every accepted bit -> identical single word 8'h8D; no output before the 8th accepted bit.
- out_ready=0; feed 5 words 8'h01,8'h02,8'h03,8'h04,8'h05 -> level=4 and out_word held at 8'h01. 5th word dropped: overflow=1, drop_count=1. Then out_ready=1 -> 8'h01..8'h04 pop in order, level=0, out_valid=0.
- FIFO full, out_ready=1 asserted on the same edge the next word 8'hAA completes -> 8'hAA accepted, level stays 4, overflow stays 0; drain order ends with 8'hAA.
- Feed 3 bits (1,1,1), pulse rstn low asynchronously between edges -> outputs 0 immediately. Then bits 0,0,0,0,0,0,0,0 -> out_word=8'h00, not contaminated by the earlier 1s.
- overflow=1, drop_count=3; pulse clr_stats alone -> 0/0. Then force a drop on the same edge as clr_stats -> overflow=1, drop_count=1.
